// File: rtl/shift_seq_pkg.sv
// Shared FSM states, direction codes and the single-step shift/rotate function
// used by the sequential shifter.
package shift_seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Step operates on a wide zero-extended word; msb marks the real register top.
  localparam int STEP_MAX_W = 32;
  localparam int STEP_IDX_W = 5;

  function automatic logic [STEP_MAX_W-1:0] shift_step(
    input logic [STEP_MAX_W-1:0] r,
    input logic [STEP_IDX_W-1:0] msb,
    input logic                  dir,
    input logic                  rot,
    input logic                  fill
  );
    logic                  in_bit;
    logic [STEP_MAX_W-1:0] res;
    in_bit = fill;
    res    = r;
    if (dir == DIR_LEFT) begin
      in_bit = rot ? r[msb] : fill;
      res    = (r << 1) | STEP_MAX_W'(in_bit);
    end
    if (dir == DIR_RIGHT) begin
      in_bit = rot ? r[0] : fill;
      res    = (r >> 1) | (STEP_MAX_W'(in_bit) << msb);
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Multi-flop synchronizer for an asynchronous button with a rising-edge pulse.
// The pulse is held off until the chain has refilled after reset.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q   <= sync_q[SYNC_STAGES-1];
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  // A button held through reset must not look like a fresh press.
  assign rise  = vld_pipe[SYNC_STAGES] & level & ~prev_q;

endmodule

// File: rtl/shift_seq_8bit.sv
// Button-started shifter: loads switch data, then shifts/rotates it one
// position per step with a start/busy/done handshake on the LEDs.
module shift_seq_8bit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int AMT_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int STEP_DIV    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH+AMT_W+1:0]   sw,
  input  logic [1:0]               btn,
  output logic [WIDTH-1:0]         led,
  output logic                     busy,
  output logic                     done
);

  localparam int DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DIR_BIT = WIDTH + AMT_W;
  localparam int ROT_BIT = WIDTH + AMT_W + 1;

  logic [1:0] btn_lvl, btn_rise;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (btn[i]),
      .level(btn_lvl[i]),
      .rise (btn_rise[i])
    );
  end

  logic start_p, fill_s, sync_unused;
  assign start_p     = btn_rise[1];
  assign fill_s      = btn_lvl[0];
  assign sync_unused = btn_lvl[1] ^ btn_rise[0];

  logic [AMT_W-1:0] sw_amt;
  assign sw_amt = sw[WIDTH +: AMT_W];

  state_t           state;
  logic [AMT_W-1:0] amt_q;
  logic [DIV_W-1:0] div_cnt;
  logic             dir_q, rot_q, fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      amt_q   <= '0;
      div_cnt <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start_p) state <= S_LOAD;
        S_LOAD: begin
          led     <= sw[WIDTH-1:0];
          amt_q   <= sw_amt;
          dir_q   <= sw[DIR_BIT];
          rot_q   <= sw[ROT_BIT];
          fill_q  <= fill_s;
          busy    <= 1'b1;
          div_cnt <= '0;
          state   <= (sw_amt == '0) ? S_DONE : S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_W'(STEP_DIV - 1)) begin
            div_cnt <= '0;
            led     <= WIDTH'(shift_step(STEP_MAX_W'(led), STEP_IDX_W'(WIDTH - 1),
                                         dir_q, rot_q, fill_q));
            amt_q   <= amt_q - 1'b1;
            if (amt_q == AMT_W'(1)) state <= S_DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
